// File: rtl/fifo_wr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_ctrl
// Purpose  : FIFO controller. Arbitrates two write requesters round-robin onto
//            the memory write port, owns the write/read pointers, and produces
//            FULL/EMPTY/COUNT/ALMOST_FULL plus a read-valid strobe aligned with
//            the registered memory read data.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // requester 0
  input  logic                  req0_valid_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  // requester 1
  input  logic                  req1_valid_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  // consumer
  input  logic                  rd_inc_i,
  output logic                  rd_valid_o,
  // memory write port
  output logic                  w_inc_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  // memory read port
  output logic [ADDR_WIDTH-1:0] r_addr_o,
  // status
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  // Pointers carry one extra wrap bit so that full and empty are distinguishable
  // when the low address bits coincide.
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(AF_LEVEL);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             last_grant_q, last_grant_d;   // 0 = req0, 1 = req1
  logic             rd_valid_q, rd_valid_d;

  logic             full_w;
  logic             empty_w;
  logic [PTR_W-1:0] count_w;
  logic             grant0_w;
  logic             grant1_w;
  logic             accept_w;
  logic             pop_w;

  // Status flags straight from the registered pointers, no bypass path.
  always_comb begin
    full_w  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
              (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
    empty_w = (wptr_q == rptr_q);
    count_w = wptr_q - rptr_q;
  end

  // Round-robin grant: a lone requester always wins; on contention the one
  // that did not win last time is chosen. READY deliberately ignores rd_inc_i
  // so that a full FIFO never accepts a write on the strength of a same-cycle pop.
  always_comb begin
    grant0_w = req0_valid_i && (!req1_valid_i || last_grant_q);
    grant1_w = req1_valid_i && (!req0_valid_i || !last_grant_q);
    accept_w = (grant0_w || grant1_w) && !full_w;
    pop_w    = rd_inc_i && !empty_w;
  end

  // Next-state for pointers, grant history and read-valid strobe.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    last_grant_d = last_grant_q;
    rd_valid_d   = pop_w;
    if (accept_w) begin
      wptr_d       = wptr_q + PTR_W'(1);
      last_grant_d = grant1_w;
    end
    if (pop_w) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
  end

  // State registers; reset discards all stored words and favours req0 first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Output drive.
  always_comb begin
    req0_ready_o  = grant0_w && !full_w;
    req1_ready_o  = grant1_w && !full_w;
    w_inc_o       = accept_w;
    w_addr_o      = wptr_q[ADDR_WIDTH-1:0];
    wr_data_o     = grant1_w ? req1_data_i : req0_data_i;
    r_addr_o      = rptr_q[ADDR_WIDTH-1:0];
    rd_valid_o    = rd_valid_q;
    full_o        = full_w;
    empty_o       = empty_w;
    almost_full_o = (count_w >= AF_THRESH);
    count_o       = count_w;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter_ctrl
// Purpose  : Directed, table-driven bench for fifo_wr_arbiter_ctrl, with a
//            small registered-read memory model attached to the write/read ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       req0_valid_i = 1'b0;
  logic [7:0] req0_data_i  = '0;
  logic       req0_ready_o;
  logic       req1_valid_i = 1'b0;
  logic [7:0] req1_data_i  = '0;
  logic       req1_ready_o;
  logic       rd_inc_i = 1'b0;
  logic       rd_valid_o;
  logic       w_inc_o;
  logic [1:0] w_addr_o;
  logic [7:0] wr_data_o;
  logic [1:0] r_addr_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic [2:0] count_o;

  fifo_wr_arbiter_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .AF_LEVEL  (3)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .rd_inc_i     (rd_inc_i),
    .rd_valid_o   (rd_valid_o),
    .w_inc_o      (w_inc_o),
    .w_addr_o     (w_addr_o),
    .wr_data_o    (wr_data_o),
    .r_addr_o     (r_addr_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .almost_full_o(almost_full_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: synchronous write, registered read, contents not reset.
  logic [7:0] mem [4];
  logic [7:0] rd_data;
  always @(posedge clk_i) begin
    if (w_inc_o) mem[w_addr_o] <= wr_data_o;
    rd_data <= mem[r_addr_o];
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic        rd;
    logic [29:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // {count, empty, full, af, rdy0, rdy1, w_inc, wdata(if w_inc), w_addr, r_addr, rd_valid, rdata(if valid)}
  function automatic logic [29:0] pack(logic [2:0] cnt, logic e, logic f, logic af,
                                       logic r0, logic r1, logic wi, logic [7:0] wd,
                                       logic [1:0] wa, logic [1:0] ra, logic rv,
                                       logic [7:0] rdat);
    return {cnt, e, f, af, r0, r1, wi, (wi ? wd : 8'h00), wa, ra, rv, (rv ? rdat : 8'h00)};
  endfunction

  task automatic add(string nm, logic rst, logic v0, logic [7:0] d0, logic v1,
                     logic [7:0] d1, logic rd, logic [2:0] cnt, logic e, logic f,
                     logic af, logic r0, logic r1, logic wi, logic [7:0] wd,
                     logic [1:0] wa, logic [1:0] ra, logic rv, logic [7:0] rdat);
    vec_t v;
    v.name = nm; v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rd = rd;
    v.exp  = pack(cnt, e, f, af, r0, r1, wi, wd, wa, ra, rv, rdat);
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", nm, got, exp);
  endtask

  function automatic logic [29:0] observe();
    return pack(count_o, empty_o, full_o, almost_full_o, req0_ready_o, req1_ready_o,
                w_inc_o, wr_data_o, w_addr_o, r_addr_o, rd_valid_o, rd_data);
  endfunction

  initial begin
    logic [7:0] exp_rd;

    // ---------------- vector table ----------------
    //   name             rst v0 d0     v1 d1     rd  cnt e f af r0 r1 wi wd     wa ra rv rdat
    add("push_a1",        0, 1, 8'hA1, 0, 8'h00, 0,  0, 1,0,0, 1, 0, 1, 8'hA1, 0, 0, 0, 8'h00);
    add("push_a2",        0, 1, 8'hA2, 0, 8'h00, 0,  1, 0,0,0, 1, 0, 1, 8'hA2, 1, 0, 0, 8'h00);
    add("push_a3",        0, 1, 8'hA3, 0, 8'h00, 0,  2, 0,0,0, 1, 0, 1, 8'hA3, 2, 0, 0, 8'h00);
    add("push_a4_af",     0, 1, 8'hA4, 0, 8'h00, 0,  3, 0,0,1, 1, 0, 1, 8'hA4, 3, 0, 0, 8'h00);
    add("full_blocks",    0, 1, 8'hA5, 0, 8'h00, 0,  4, 0,1,1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add("pop_from_full",  0, 0, 8'h00, 0, 8'h00, 1,  4, 0,1,1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add("pop_a1",         0, 0, 8'h00, 0, 8'h00, 1,  3, 0,0,1, 0, 0, 0, 8'h00, 0, 1, 1, 8'hA1);
    add("pop_a2",         0, 0, 8'h00, 0, 8'h00, 1,  2, 0,0,0, 0, 0, 0, 8'h00, 0, 2, 1, 8'hA2);
    add("pop_a3",         0, 0, 8'h00, 0, 8'h00, 1,  1, 0,0,0, 0, 0, 0, 8'h00, 0, 3, 1, 8'hA3);
    add("pop_a4_empty",   0, 0, 8'h00, 0, 8'h00, 1,  0, 1,0,0, 0, 0, 0, 8'h00, 0, 0, 1, 8'hA4);
    add("rd_while_empty", 0, 0, 8'h00, 0, 8'h00, 1,  0, 1,0,0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add("reset_row",      1, 0, 8'h00, 0, 8'h00, 0,  0, 1,0,0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add("arb_r0_first",   0, 1, 8'h10, 1, 8'h20, 0,  0, 1,0,0, 1, 0, 1, 8'h10, 0, 0, 0, 8'h00);
    add("arb_r1",         0, 1, 8'h11, 1, 8'h20, 0,  1, 0,0,0, 0, 1, 1, 8'h20, 1, 0, 0, 8'h00);
    add("arb_r0",         0, 1, 8'h11, 1, 8'h21, 0,  2, 0,0,0, 1, 0, 1, 8'h11, 2, 0, 0, 8'h00);
    add("arb_r1_af",      0, 1, 8'h12, 1, 8'h21, 0,  3, 0,0,1, 0, 1, 1, 8'h21, 3, 0, 0, 8'h00);
    add("full_pop_nowr",  0, 0, 8'h00, 1, 8'h22, 1,  4, 0,1,1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add("push_resumes",   0, 0, 8'h00, 1, 8'h22, 0,  3, 0,0,1, 0, 1, 1, 8'h22, 0, 1, 1, 8'h10);
    add("refull_idle",    0, 0, 8'h00, 0, 8'h00, 0,  4, 0,1,1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00);
    add("drain_a",        0, 0, 8'h00, 0, 8'h00, 1,  4, 0,1,1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00);
    add("drain_b",        0, 0, 8'h00, 0, 8'h00, 1,  3, 0,0,1, 0, 0, 0, 8'h00, 1, 2, 1, 8'h20);
    // Steady push+pop at COUNT=2 with wptr starting at 5 and rptr at 3.
    for (int j = 0; j < 10; j++) begin
      case (j)
        0:       exp_rd = 8'h11;
        1:       exp_rd = 8'h21;
        2:       exp_rd = 8'h22;
        default: exp_rd = 8'h30 + 8'(j - 3);
      endcase
      add($sformatf("stream_%0d", j), 0, 1, 8'h30 + 8'(j), 0, 8'h00, 1,
          2, 0,0,0, 1, 0, 1, 8'h30 + 8'(j), 2'(5 + j), 2'(3 + j), 1, exp_rd);
    end
    add("stream_tail",    0, 0, 8'h00, 0, 8'h00, 0,  2, 0,0,0, 0, 0, 0, 8'h00, 3, 1, 1, 8'h37);

    // ---------------- async reset pulse mid-cycle ----------------
    #3 rst_i = 1'b1;
    #1;
    chk("rst_async_flags", {27'd0, count_o, empty_o, full_o}, {27'd0, 3'd0, 1'b1, 1'b0});
    chk("rst_async_rv_af", {30'd0, rd_valid_o, almost_full_o}, 32'd0);
    req0_valid_i = 1'b1;
    #1;
    chk("rst_ready0_follows", {30'd0, req0_ready_o, req1_ready_o}, 32'd2);
    req0_valid_i = 1'b0; req1_valid_i = 1'b1;
    #1;
    chk("rst_ready1_follows", {30'd0, req0_ready_o, req1_ready_o}, 32'd1);
    req1_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      rst_i        = tbl[i].rst;
      req0_valid_i = tbl[i].v0;
      req0_data_i  = tbl[i].d0;
      req1_valid_i = tbl[i].v1;
      req1_data_i  = tbl[i].d1;
      rd_inc_i     = tbl[i].rd;
      @(negedge clk_i);
      chk(tbl[i].name, {2'b00, observe()}, {2'b00, tbl[i].exp});
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;

    // ---------------- reset at COUNT=3 ----------------
    req0_valid_i = 1'b1; req0_data_i = 8'h40; rd_inc_i = 1'b0;
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    #2;
    chk("count3_before_rst", {29'd0, count_o}, 32'd3);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_empty", {28'd0, empty_o, full_o, almost_full_o, rd_valid_o}, 32'h8);
    chk("rst_mid_count_ptrs", {25'd0, count_o, w_addr_o, r_addr_o}, 32'd0);
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    chk("rst_arb_r0_first", {30'd0, req0_ready_o, req1_ready_o}, 32'd2);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_idle", {28'd0, empty_o, full_o, w_inc_o, rd_valid_o}, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
